// File: rtl/pipe_mem_arbiter.sv
// Arbiter and stall controller for the single-port memory shared by the IF and MEM
// pipeline stages. Data accesses win in IDLE, and an access in flight is never preempted.
module pipe_mem_arbiter #(
  parameter int AW  = 32,
  parameter int DW  = 32,
  parameter int TMO = 255
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  input  logic          m_req,
  input  logic          m_we,
  input  logic [AW-1:0] m_addr,
  input  logic [DW-1:0] m_wdata,
  output logic [DW-1:0] m_rdata,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ready,
  output logic          pc_en,
  output logic          ifid_en,
  output logic          ifid_nop,
  output logic          pipe_en,
  output logic          mw_nop,
  output logic          tmo_err
);

  localparam int CW = $clog2(TMO + 1);
  localparam logic [CW-1:0] TMO_C = CW'(TMO);

  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_D} state_t;

  state_t        state, state_nx;
  logic [AW-1:0] own_addr;
  logic [DW-1:0] own_wdata;
  logic          own_we;
  logic [DW-1:0] ibuf;
  logic          ibuf_valid;
  logic [CW-1:0] wait_cnt, wait_cnt_nx;
  logic          busy, grant_d, grant_f, d_own, f_own;
  logic          d_done, f_done, d_wait, f_wait;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // In IDLE the requester drives the memory directly; once busy, the captured owner does.
  always_comb begin
    state_nx  = state;
    busy      = (state != IDLE);
    grant_d   = ~busy & m_req;
    grant_f   = ~busy & ~m_req & if_req & ~ibuf_valid;
    d_own     = grant_d | (state == BUSY_D);
    f_own     = grant_f | (state == BUSY_IF);
    mem_req   = (d_own | f_own) & ~reset;
    mem_addr  = if_addr;
    mem_wdata = '0;
    mem_we    = 1'b0;
    if (busy) begin
      mem_addr  = own_addr;
      mem_wdata = own_wdata;
      mem_we    = d_own & own_we;
    end else if (grant_d) begin
      mem_addr  = m_addr;
      mem_wdata = m_wdata;
      mem_we    = m_we;
    end
    d_done = d_own & mem_ready;
    f_done = f_own & mem_ready;
    d_wait = m_req & ~d_done;
    f_wait = if_req & ~ibuf_valid & ~f_done;
    case (state)
      IDLE: begin
        if (grant_d & ~mem_ready)      state_nx = BUSY_D;
        else if (grant_f & ~mem_ready) state_nx = BUSY_IF;
      end
      BUSY_IF, BUSY_D: begin
        if (mem_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      own_addr  <= '0;
      own_wdata <= '0;
      own_we    <= 1'b0;
    end else if (grant_d | grant_f) begin
      own_addr  <= mem_addr;
      own_wdata <= mem_wdata;
      own_we    <= mem_we;
    end
  end

  // Only busy cycles count as waiting; the grant cycle itself is not a wait state.
  always_comb begin
    wait_cnt_nx = wait_cnt;
    if (busy & ~mem_ready) begin
      if (wait_cnt != TMO_C) wait_cnt_nx = wait_cnt + 1'b1;
    end else if (mem_ready) begin
      wait_cnt_nx = '0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wait_cnt <= '0;
      tmo_err  <= 1'b0;
    end else begin
      wait_cnt <= wait_cnt_nx;
      if (wait_cnt_nx == TMO_C) tmo_err <= 1'b1;
    end
  end

  // A fetch finishing while the pipe is frozen for data must be parked, or it would be lost.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ibuf       <= '0;
      ibuf_valid <= 1'b0;
    end else if (f_done & d_wait) begin
      ibuf       <= mem_rdata;
      ibuf_valid <= 1'b1;
    end else if (pc_en) begin
      ibuf_valid <= 1'b0;
    end
  end

  assign pipe_en  = ~d_wait;
  assign mw_nop   = d_wait;
  assign ifid_en  = ~d_wait;
  assign ifid_nop = f_wait & ~d_wait;
  assign pc_en    = ~d_wait & ~f_wait;
  assign m_rdata  = mem_rdata;
  assign if_rdata = ibuf_valid ? ibuf : mem_rdata;

endmodule

// File: tb/tb_pipe_mem_arbiter.sv
// Testbench for pipe_mem_arbiter: directed scenarios followed by random traffic,
// all outputs compared against a transaction-level model of the arbitration rules.
module tb_pipe_mem_arbiter;

  localparam int TMO = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        if_req, m_req, m_we, mem_ready;
  logic [31:0] if_addr, m_addr, m_wdata, mem_rdata;
  logic [31:0] if_rdata, m_rdata, mem_addr, mem_wdata;
  logic        mem_req, mem_we, pc_en, ifid_en, ifid_nop, pipe_en, mw_nop, tmo_err;

  int tests = 0;
  int fails = 0;

  pipe_mem_arbiter #(.AW(32), .DW(32), .TMO(TMO)) dut (
    .clock(clock), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .pc_en(pc_en), .ifid_en(ifid_en), .ifid_nop(ifid_nop), .pipe_en(pipe_en),
    .mw_nop(mw_nop), .tmo_err(tmo_err)
  );

  always #5 clock = ~clock;

  // Model: one outstanding transaction record, a parked instruction and a sticky timeout flag.
  bit          p_act, p_data, p_we, b_valid, t_flag;
  logic [31:0] p_addr, p_wdata, b_data;
  int          p_wait;
  bit          s_srv, s_data, s_we, s_done, s_dstall, s_fstall;
  logic [31:0] s_addr, s_wdata;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $display("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
      $error("[TB] %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    p_act = 0; p_data = 0; p_we = 0; p_wait = 0;
    b_valid = 0; b_data = '0; t_flag = 0;
    p_addr = '0; p_wdata = '0;
  endtask

  task automatic eval();
    s_srv = 1; s_data = 0; s_we = 0; s_addr = '0; s_wdata = '0;
    if (p_act) begin
      s_data = p_data; s_addr = p_addr; s_wdata = p_wdata; s_we = p_we;
    end else if (m_req) begin
      s_data = 1; s_addr = m_addr; s_wdata = m_wdata; s_we = m_we;
    end else if (if_req && !b_valid) begin
      s_addr = if_addr;
    end else begin
      s_srv = 0;
    end
    s_done   = s_srv && mem_ready;
    s_dstall = m_req && !(s_srv && s_data && s_done);
    s_fstall = if_req && !b_valid && !(s_srv && !s_data && s_done);
    check_output("mem_req", mem_req, s_srv);
    if (s_srv) begin
      check_output("mem_addr", mem_addr, s_addr);
      check_output("mem_we", mem_we, s_data && s_we);
      if (s_data) check_output("mem_wdata", mem_wdata, s_wdata);
    end
    check_output("pipe_en", pipe_en, !s_dstall);
    check_output("mw_nop", mw_nop, s_dstall);
    check_output("ifid_en", ifid_en, !s_dstall);
    check_output("ifid_nop", ifid_nop, s_fstall && !s_dstall);
    check_output("pc_en", pc_en, !s_dstall && !s_fstall);
    check_output("tmo_err", tmo_err, t_flag);
    check_output("if_rdata", if_rdata, b_valid ? b_data : mem_rdata);
    if (s_srv && s_data && s_done && !s_we) check_output("m_rdata", m_rdata, mem_rdata);
  endtask

  task automatic advance();
    bit was;
    was = p_act;
    @(posedge clock);
    if (s_srv && s_done) begin
      p_act = 0;
      p_wait = 0;
      if (!s_data && s_dstall) begin
        b_valid = 1;
        b_data = mem_rdata;
      end
    end else if (s_srv) begin
      if (!was) begin
        p_act = 1; p_data = s_data; p_addr = s_addr; p_wdata = s_wdata; p_we = s_we;
      end else begin
        if (p_wait < TMO) p_wait++;
        if (p_wait == TMO) t_flag = 1;
      end
    end
    if (!s_dstall && !s_fstall) b_valid = 0;
    #1;
  endtask

  task automatic apply_stimulus();
    @(negedge clock);
    eval();
    advance();
  endtask

  task automatic drive(input bit ir, input logic [31:0] ia, input bit mr, input bit mw,
                       input logic [31:0] ma, input bit rdy, input logic [31:0] rd);
    if_req = ir; if_addr = ia; m_req = mr; m_we = mw; m_addr = ma;
    m_wdata = 32'hA5A5_0000 ^ ma; mem_ready = rdy; mem_rdata = rd;
  endtask

  initial begin
    reset = 1;
    model_reset();
    drive(1, 32'h10, 1, 0, 32'h20, 1, 32'h0);
    #3;
    check_output("reset_mem_req", mem_req, 1'b0);
    check_output("reset_tmo_err", tmo_err, 1'b0);
    drive(0, 0, 0, 0, 0, 0, 0);
    @(negedge clock);
    reset = 0;
    #1;

    // zero-wait fetch stream
    for (int i = 0; i < 4; i++) begin
      drive(1, 32'h1000 + 4 * i, 0, 0, 0, 1, 32'h1111_0000 + i);
      @(negedge clock);
      eval();
      check_output("zw_mem_req", mem_req, 1'b1);
      check_output("zw_pc_en", pc_en, 1'b1);
      check_output("zw_ifid_nop", ifid_nop, 1'b0);
      check_output("zw_if_rdata", if_rdata, 32'h1111_0000 + i);
      advance();
    end

    // fetch at 0x40 with three wait states; requester address changes mid-access
    drive(1, 32'h40, 0, 0, 0, 0, 32'h0);
    apply_stimulus();
    for (int i = 0; i < 2; i++) begin
      drive(1, 32'h99, 0, 0, 0, 0, 32'h0);
      @(negedge clock);
      eval();
      check_output("fw_pc_en", pc_en, 1'b0);
      check_output("fw_ifid_nop", ifid_nop, 1'b1);
      check_output("fw_pipe_en", pipe_en, 1'b1);
      advance();
    end
    drive(1, 32'h99, 0, 0, 0, 1, 32'h0BAD_F00D);
    @(negedge clock);
    eval();
    check_output("fw_done_addr", mem_addr, 32'h40);
    check_output("fw_done_pc_en", pc_en, 1'b1);
    advance();

    // load at 0x100 wins over a simultaneous fetch
    drive(1, 32'h50, 1, 0, 32'h100, 0, 32'h0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      eval();
      check_output("dp_mem_addr", mem_addr, 32'h100);
      check_output("dp_pipe_en", pipe_en, 1'b0);
      check_output("dp_mw_nop", mw_nop, 1'b1);
      advance();
    end
    drive(1, 32'h50, 1, 0, 32'h100, 1, 32'h0000_CAFE);
    @(negedge clock);
    eval();
    check_output("dp_m_rdata", m_rdata, 32'h0000_CAFE);
    check_output("dp_pipe_en_done", pipe_en, 1'b1);
    advance();
    drive(1, 32'h50, 0, 0, 0, 0, 32'h0);
    @(negedge clock);
    eval();
    check_output("dp_fetch_next", mem_addr, 32'h50);
    advance();
    drive(1, 32'h50, 0, 0, 0, 1, 32'h0);
    apply_stimulus();

    // data request arriving while a fetch is in flight
    drive(1, 32'h200, 0, 0, 0, 0, 32'h0);
    apply_stimulus();
    drive(1, 32'h200, 1, 0, 32'h300, 1, 32'hDEAD_BEEF);
    @(negedge clock);
    eval();
    check_output("bi_pc_en", pc_en, 1'b0);
    advance();
    drive(1, 32'h204, 1, 0, 32'h300, 0, 32'h0);
    @(negedge clock);
    eval();
    check_output("bi_data_addr", mem_addr, 32'h300);
    check_output("bi_if_rdata_held", if_rdata, 32'hDEAD_BEEF);
    advance();
    drive(1, 32'h204, 1, 0, 32'h300, 1, 32'h1234_5678);
    @(negedge clock);
    eval();
    check_output("bi_pc_en_done", pc_en, 1'b1);
    check_output("bi_if_rdata", if_rdata, 32'hDEAD_BEEF);
    advance();
    drive(1, 32'h204, 0, 0, 0, 0, 32'h7777_7777);
    @(negedge clock);
    eval();
    check_output("bi_refetch", mem_req, 1'b1);
    check_output("bi_buf_cleared", if_rdata, 32'h7777_7777);
    advance();
    drive(1, 32'h204, 0, 0, 0, 1, 32'h0);
    apply_stimulus();

    // store that never completes: timeout, then asynchronous reset
    drive(0, 0, 1, 1, 32'h400, 0, 32'h0);
    apply_stimulus();
    for (int i = 0; i < 3; i++) apply_stimulus();
    @(negedge clock);
    eval();
    check_output("to_before", tmo_err, 1'b0);
    advance();
    @(negedge clock);
    eval();
    check_output("to_err", tmo_err, 1'b1);
    check_output("to_mem_req", mem_req, 1'b1);
    check_output("to_mem_we", mem_we, 1'b1);
    advance();
    #2 reset = 1;
    #1;
    check_output("rst_async_req", mem_req, 1'b0);
    check_output("rst_tmo_clear", tmo_err, 1'b0);
    drive(0, 0, 0, 0, 0, 0, 0);
    @(negedge clock);
    reset = 0;
    model_reset();
    #1;

    // random traffic
    for (int i = 0; i < 500; i++) begin
      drive($urandom_range(0, 99) < 75, $urandom, $urandom_range(0, 99) < 30,
            $urandom_range(0, 1) == 1, $urandom, $urandom_range(0, 99) < 60, $urandom);
      apply_stimulus();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
